rvx_tcm_dual_port: RTL and testbench

// - Word-organised on-chip RAM tightly coupled to the RVX core.
// - Port 0 is read-only and serves the core instruction bus.
// - Port 1 is read/write with byte strobes and serves the core data bus.
// - One-cycle request/response protocol on both ports. The storage array is named "tcm" and is

---
 rtl/rvx_tcm_dual_port.sv | 90 +++++++++
 tb/tb_rvx_tcm_dual_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_tcm_dual_port.sv
// Dual-port tightly coupled RAM for the RVX core: port 0 is a read-only instruction port and
// port 1 is a read/write data port with byte strobes. Both ports answer every request in one cycle.
module rvx_tcm_dual_port #(
  parameter int unsigned MEMORY_SIZE_IN_BYTES = 8192
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] port0_address,
  input  logic        port0_rrequest,
  output logic [31:0] port0_rdata,
  output logic        port0_rresponse,
  input  logic [31:0] port1_address,
  input  logic        port1_rrequest,
  output logic [31:0] port1_rdata,
  output logic        port1_rresponse,
  input  logic [31:0] port1_wdata,
  input  logic [3:0]  port1_wstrobe,
  input  logic        port1_wrequest,
  output logic        port1_wresponse
);

  localparam int unsigned AW    = $clog2(MEMORY_SIZE_IN_BYTES);
  localparam int unsigned Depth = MEMORY_SIZE_IN_BYTES / 4;

  // Word storage; deliberately left out of reset so contents survive reset_n.
  logic [31:0] tcm [0:Depth-1];

  logic [AW-3:0] port0_index;
  logic [AW-3:0] port1_index;

  // Upper bits alias into the array; low bits are the core's alignment concern.
  assign port0_index = port0_address[AW-1:2];
  assign port1_index = port1_address[AW-1:2];

  logic unused_address_bits;
  assign unused_address_bits = ^{port0_address[31:AW], port0_address[1:0],
                                 port1_address[31:AW], port1_address[1:0]};

  logic [31:0] port0_rdata_d, port0_rdata_q;
  logic        port0_rresponse_d, port0_rresponse_q;
  logic [31:0] port1_rdata_d, port1_rdata_q;
  logic        port1_rresponse_d, port1_rresponse_q;
  logic        port1_wresponse_d, port1_wresponse_q;

  always_comb begin
    port0_rdata_d     = port0_rdata_q;
    port0_rresponse_d = port0_rrequest;
    port1_rdata_d     = port1_rdata_q;
    port1_rresponse_d = port1_rrequest;
    port1_wresponse_d = port1_wrequest;
    if (port0_rrequest) begin
      port0_rdata_d = tcm[port0_index];
    end
    if (port1_rrequest) begin
      port1_rdata_d = tcm[port1_index];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port0_rdata_q     <= '0;
      port0_rresponse_q <= 1'b0;
      port1_rdata_q     <= '0;
      port1_rresponse_q <= 1'b0;
      port1_wresponse_q <= 1'b0;
    end else begin
      port0_rdata_q     <= port0_rdata_d;
      port0_rresponse_q <= port0_rresponse_d;
      port1_rdata_q     <= port1_rdata_d;
      port1_rresponse_q <= port1_rresponse_d;
      port1_wresponse_q <= port1_wresponse_d;
    end
  end

  // Non-blocking update gives read-before-write on both ports for free.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 4; n++) begin
      if (port1_wrequest && port1_wstrobe[n]) begin
        tcm[port1_index][8*n +: 8] <= port1_wdata[8*n +: 8];
      end
    end
  end

  assign port0_rdata     = port0_rdata_q;
  assign port0_rresponse = port0_rresponse_q;
  assign port1_rdata     = port1_rdata_q;
  assign port1_rresponse = port1_rresponse_q;
  assign port1_wresponse = port1_wresponse_q;

endmodule

// File: tb/tb_rvx_tcm_dual_port.sv
// Bench for rvx_tcm_dual_port: a word-array model predicts every output each cycle, and a few
// directed scenarios pin literal values.
module tb_rvx_tcm_dual_port;

  localparam int unsigned MEM_BYTES = 8192;
  localparam int unsigned DEPTH     = MEM_BYTES / 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] port0_address;
  logic        port0_rrequest;
  logic [31:0] port0_rdata;
  logic        port0_rresponse;
  logic [31:0] port1_address;
  logic        port1_rrequest;
  logic [31:0] port1_rdata;
  logic        port1_rresponse;
  logic [31:0] port1_wdata;
  logic [3:0]  port1_wstrobe;
  logic        port1_wrequest;
  logic        port1_wresponse;

  rvx_tcm_dual_port #(.MEMORY_SIZE_IN_BYTES(MEM_BYTES)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .port0_address   (port0_address),
    .port0_rrequest  (port0_rrequest),
    .port0_rdata     (port0_rdata),
    .port0_rresponse (port0_rresponse),
    .port1_address   (port1_address),
    .port1_rrequest  (port1_rrequest),
    .port1_rdata     (port1_rdata),
    .port1_rresponse (port1_rresponse),
    .port1_wdata     (port1_wdata),
    .port1_wstrobe   (port1_wstrobe),
    .port1_wrequest  (port1_wrequest),
    .port1_wresponse (port1_wresponse)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  // Reference model: plain word array plus the expected registered outputs.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] exp_p0_data, exp_p1_data;
  logic        exp_p0_resp, exp_p1_resp, exp_wresp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_p0_data <= '0;
      exp_p1_data <= '0;
      exp_p0_resp <= 1'b0;
      exp_p1_resp <= 1'b0;
      exp_wresp   <= 1'b0;
    end else begin
      exp_p0_resp <= port0_rrequest;
      exp_p1_resp <= port1_rrequest;
      exp_wresp   <= port1_wrequest;
      if (port0_rrequest) exp_p0_data <= mem[port0_address[12:2]];
      if (port1_rrequest) exp_p1_data <= mem[port1_address[12:2]];
      if (port1_wrequest) begin
        for (int n = 0; n < 4; n++) begin
          if (port1_wstrobe[n]) mem[port1_address[12:2]][8*n +: 8] <= port1_wdata[8*n +: 8];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("model port0_rresponse", {31'd0, port0_rresponse}, {31'd0, exp_p0_resp});
      check("model port0_rdata", port0_rdata, exp_p0_data);
      check("model port1_rresponse", {31'd0, port1_rresponse}, {31'd0, exp_p1_resp});
      check("model port1_rdata", port1_rdata, exp_p1_data);
      check("model port1_wresponse", {31'd0, port1_wresponse}, {31'd0, exp_wresp});
    end
  end

  task automatic idle();
    port0_rrequest = 1'b0;
    port1_rrequest = 1'b0;
    port1_wrequest = 1'b0;
    port0_address  = '0;
    port1_address  = '0;
    port1_wdata    = '0;
    port1_wstrobe  = '0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.tcm[idx] = v;
    mem[idx]     = v;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[31:13] = '0;
    a[12:2] = 11'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) a[12:2] = 11'($urandom);
    return a;
  endfunction

  initial begin
    logic [31:0] w;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      preload(i, w);
    end

    // Reset held with read requests active.
    #1 reset_n = 1'b0;
    port0_rrequest = 1'b1;
    port1_rrequest = 1'b1;
    check_en = 1'b1;
    repeat (3) @(negedge clock);
    check("reset port0_rresponse", {31'd0, port0_rresponse}, 32'd0);
    check("reset port1_rresponse", {31'd0, port1_rresponse}, 32'd0);
    check("reset port1_wresponse", {31'd0, port1_wresponse}, 32'd0);
    check("reset port0_rdata", port0_rdata, 32'd0);
    check("reset port1_rdata", port1_rdata, 32'd0);
    reset_n = 1'b1;
    idle();
    @(negedge clock);

    // Preloaded word read over port 0.
    preload(5, 32'h12345678);
    port0_rrequest = 1'b1;
    port0_address  = 32'h14;
    @(negedge clock);
    check("preload rdata", port0_rdata, 32'h12345678);
    check("preload rresponse", {31'd0, port0_rresponse}, 32'd1);
    idle();

    // Partial byte-strobe write.
    preload(2, 32'hdeadbeef);
    port1_wrequest = 1'b1;
    port1_address  = 32'h08;
    port1_wdata    = 32'hAABBCCDD;
    port1_wstrobe  = 4'b0101;
    @(negedge clock);
    check("strobe wresponse", {31'd0, port1_wresponse}, 32'd1);
    check("strobe tcm[2]", dut.tcm[2], 32'hdebbbedd);
    idle();

    // Read and write of the same word together: old word first, new word after.
    preload(2, 32'h5);
    port1_wrequest = 1'b1;
    port1_rrequest = 1'b1;
    port1_address  = 32'h08;
    port1_wdata    = 32'h1;
    port1_wstrobe  = 4'hF;
    @(negedge clock);
    check("rdw old rdata", port1_rdata, 32'h5);
    check("rdw wresponse", {31'd0, port1_wresponse}, 32'd1);
    idle();
    port1_rrequest = 1'b1;
    port1_address  = 32'h08;
    @(negedge clock);
    check("rdw new rdata", port1_rdata, 32'h1);
    idle();

    // Back-to-back reads with the third address aliasing onto word 0.
    preload(0, 32'hA0A0_0000);
    preload(1, 32'hA1A1_1111);
    port0_rrequest = 1'b1;
    port0_address  = 32'h0;
    @(negedge clock);
    check("b2b read0", port0_rdata, 32'hA0A0_0000);
    check("b2b resp0", {31'd0, port0_rresponse}, 32'd1);
    port0_address = 32'h4;
    @(negedge clock);
    check("b2b read1", port0_rdata, 32'hA1A1_1111);
    check("b2b resp1", {31'd0, port0_rresponse}, 32'd1);
    port0_address = 32'h2000;
    @(negedge clock);
    check("b2b alias read", port0_rdata, 32'hA0A0_0000);
    check("b2b resp2", {31'd0, port0_rresponse}, 32'd1);
    idle();

    // Port 0 streams reads while port 1 writes elsewhere.
    for (int k = 0; k < 4; k++) begin
      port0_rrequest = 1'b1;
      port0_address  = (k % 2 == 1) ? 32'h4 : 32'h0;
      port1_wrequest = (k == 1);
      port1_address  = 32'h1000;
      port1_wdata    = 32'h1;
      port1_wstrobe  = 4'hF;
      @(negedge clock);
      check("stream p0 rdata", port0_rdata, (k % 2 == 1) ? 32'hA1A1_1111 : 32'hA0A0_0000);
      check("stream p0 resp", {31'd0, port0_rresponse}, 32'd1);
    end
    idle();
    @(negedge clock);
    check("stream tcm[1024]", dut.tcm[1024], 32'h1);

    // Randomised traffic with occasional resets (no writes while in reset).
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset_n        = 1'b0;
        port1_wrequest = 1'b0;
      end else begin
        reset_n        = 1'b1;
        port1_wrequest = $urandom_range(0, 2) == 0;
      end
      port0_rrequest = $urandom_range(0, 3) != 0;
      port1_rrequest = $urandom_range(0, 1) == 0;
      port0_address  = rand_addr();
      port1_address  = ($urandom_range(0, 3) == 0) ? port0_address : rand_addr();
      port1_wdata    = $urandom;
      port1_wstrobe  = 4'($urandom);
      @(negedge clock);
    end
    reset_n = 1'b1;
    idle();
    repeat (2) @(negedge clock);
    check_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("final array word", dut.tcm[i], mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
